// File: rtl/pc_fetch_pkg.sv
// Shared CPU constants and small helpers used by the fetch stage and the next-PC unit.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_PC   = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Bundle of the fetch-stage signals: next-PC feedback, instruction SRAM port and decode handshake.
interface pc_fetch_if;

  // Decode handshake: an instruction moves to decode on a rising edge where
  // if_valid=1 and id_allowin=1; if_valid never depends on id_allowin.
  logic [31:0] npc;
  logic        redirect;
  logic        id_allowin;
  logic [31:0] pc_out;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  modport master (
    input  npc, redirect, id_allowin, inst_sram_rdata,
    output pc_out, inst_sram_en, inst_sram_addr,
    output if_valid, if_pc, if_inst, if_adel
  );

  modport slave (
    output npc, redirect, id_allowin, inst_sram_rdata,
    input  pc_out, inst_sram_en, inst_sram_addr,
    input  if_valid, if_pc, if_inst, if_adel
  );

endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM and
// holds the fetched word across decode stalls.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = RESET_PC
) (
  input  logic       clk,
  input  logic       resetn,
  pc_fetch_if.master bus
);

  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        r_fs_adel;
  logic [31:0] r_inst_buf;
  logic        r_buf_valid;

  logic        w_fs_allowin;
  logic        w_misalign;

  assign w_fs_allowin = !r_fs_valid || bus.id_allowin || bus.redirect;
  assign w_misalign   = pc_misaligned(bus.npc);

  // Reset PC sits one word early so the next-PC unit's PC+4 lands on the boot address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fs_valid  <= 1'b0;
      r_fs_pc     <= P_RESET_PC - 32'd4;
      r_fs_adel   <= 1'b0;
      r_inst_buf  <= 32'h0000_0000;
      r_buf_valid <= 1'b0;
    end else if (w_fs_allowin) begin
      r_fs_valid  <= 1'b1;
      r_fs_pc     <= bus.npc;
      r_fs_adel   <= w_misalign;
      r_buf_valid <= 1'b0;
    end else if (!r_buf_valid) begin
      // SRAM output is only trusted the cycle after a read, so grab it once per stall.
      r_inst_buf  <= bus.inst_sram_rdata;
      r_buf_valid <= 1'b1;
    end
  end

  assign bus.inst_sram_en   = w_fs_allowin && !w_misalign;
  assign bus.inst_sram_addr = word_align(bus.npc);

  assign bus.pc_out   = r_fs_pc;
  assign bus.if_pc    = r_fs_pc;
  assign bus.if_valid = r_fs_valid && !bus.redirect;
  assign bus.if_adel  = r_fs_valid && r_fs_adel;
  assign bus.if_inst  = r_fs_adel   ? NOP_INST :
                        r_buf_valid ? r_inst_buf : bus.inst_sram_rdata;

endmodule
